axi_slave_lite_regs: RTL and testbench

AXI_SLAVE_LITE_REGS -- requirements
Module: axi_slave_lite_regs

---
 rtl/axi_slave_lite_regs_pkg.sv | 50 +++++
 rtl/axi_slave_lite_regs.sv | 150 +++++++++++++++
 tb/tb_axi_slave_lite_regs.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_lite_regs_pkg.sv
// Shared constants, register-index enum and byte-strobe helpers for the
// AXI4-Lite scratch/counter register block.
package axi_slave_lite_regs_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned NUM_RW = 4;
  localparam int unsigned RESP_W = 2;

  localparam logic [4:0] OFFS_REG0    = 5'h00;
  localparam logic [4:0] OFFS_REG1    = 5'h04;
  localparam logic [4:0] OFFS_REG2    = 5'h08;
  localparam logic [4:0] OFFS_REG3    = 5'h0C;
  localparam logic [4:0] OFFS_WR_CNT  = 5'h10;
  localparam logic [4:0] OFFS_RD_CNT  = 5'h14;
  localparam logic [4:0] OFFS_UNMAP0  = 5'h18;
  localparam logic [4:0] OFFS_UNMAP1  = 5'h1C;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [IDX_W-1:0] {
    IDX_REG0   = OFFS_REG0[4:2],
    IDX_REG1   = OFFS_REG1[4:2],
    IDX_REG2   = OFFS_REG2[4:2],
    IDX_REG3   = OFFS_REG3[4:2],
    IDX_WR_CNT = OFFS_WR_CNT[4:2],
    IDX_RD_CNT = OFFS_RD_CNT[4:2],
    IDX_UNMAP0 = OFFS_UNMAP0[4:2],
    IDX_UNMAP1 = OFFS_UNMAP1[4:2]
  } reg_idx_e;

  // Scratch registers occupy the low word slots; everything above is RO/unmapped.
  function automatic logic is_rw(input reg_idx_e idx);
    return idx < IDX_WR_CNT;
  endfunction

  function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_slave_lite_regs.sv
// AXI4-Lite slave with four RW scratch registers and two RO transaction
// counters; AW and W are buffered independently, reads run in parallel.
module axi_slave_lite_regs
  import axi_slave_lite_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_L_AWADDR,
  input  logic                              S_AXI_L_AWVALID,
  output logic                              S_AXI_L_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_L_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_L_WSTRB,
  input  logic                              S_AXI_L_WVALID,
  output logic                              S_AXI_L_WREADY,
  output logic [1:0]                        S_AXI_L_BRESP,
  output logic                              S_AXI_L_BVALID,
  input  logic                              S_AXI_L_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_L_ARADDR,
  input  logic                              S_AXI_L_ARVALID,
  output logic                              S_AXI_L_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_L_RDATA,
  output logic [1:0]                        S_AXI_L_RRESP,
  output logic                              S_AXI_L_RVALID,
  input  logic                              S_AXI_L_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     CTRL
);

  logic                           rst_done;
  logic                           aw_full;
  reg_idx_e                       aw_idx;
  logic                           w_full;
  logic [DATA_W-1:0]              w_data;
  logic [STRB_W-1:0]              w_strb;
  logic [NUM_RW-1:0][DATA_W-1:0]  regs;
  logic [DATA_W-1:0]              wr_cnt;
  logic [DATA_W-1:0]              rd_cnt;
  logic                           bvalid;
  logic [RESP_W-1:0]              bresp;
  logic                           rvalid;
  logic [DATA_W-1:0]              rdata;
  logic [RESP_W-1:0]              rresp;

  logic                           aw_hs_c;
  logic                           w_hs_c;
  logic                           ar_hs_c;
  logic                           wr_exec_c;
  reg_idx_e                       ar_idx_c;
  logic [DATA_W-1:0]              rd_data_c;
  logic [RESP_W-1:0]              rd_resp_c;
  logic                           unused_addr_lsbs;

  assign unused_addr_lsbs = ^{S_AXI_L_AWADDR[1:0], S_AXI_L_ARADDR[1:0]};

  // Ready signals are gated until the first edge after reset release.
  assign S_AXI_L_AWREADY = rst_done && !aw_full;
  assign S_AXI_L_WREADY  = rst_done && !w_full;
  assign S_AXI_L_ARREADY = rst_done && (!rvalid || S_AXI_L_RREADY);

  assign aw_hs_c   = S_AXI_L_AWVALID && S_AXI_L_AWREADY;
  assign w_hs_c    = S_AXI_L_WVALID && S_AXI_L_WREADY;
  assign ar_hs_c   = S_AXI_L_ARVALID && S_AXI_L_ARREADY;
  assign wr_exec_c = aw_full && w_full && (!bvalid || S_AXI_L_BREADY);
  assign ar_idx_c  = reg_idx_e'(S_AXI_L_ARADDR[IDX_W+1:2]);

  assign S_AXI_L_BVALID = bvalid;
  assign S_AXI_L_BRESP  = bresp;
  assign S_AXI_L_RVALID = rvalid;
  assign S_AXI_L_RDATA  = rdata;
  assign S_AXI_L_RRESP  = rresp;
  assign CTRL           = regs[0];

  // Read mux sees pre-edge state, so same-edge writes are not visible.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    unique case (ar_idx_c)
      IDX_REG0, IDX_REG1, IDX_REG2, IDX_REG3: rd_data_c = regs[ar_idx_c[1:0]];
      IDX_WR_CNT:                             rd_data_c = wr_cnt;
      IDX_RD_CNT:                             rd_data_c = rd_cnt;
      default:                                rd_resp_c = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // Write address / data holding buffers and write execution.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      aw_idx  <= IDX_REG0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      regs    <= '0;
      wr_cnt  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs_c) begin
        aw_full <= 1'b1;
        aw_idx  <= reg_idx_e'(S_AXI_L_AWADDR[IDX_W+1:2]);
      end else if (wr_exec_c) begin
        aw_full <= 1'b0;
      end
      if (w_hs_c) begin
        w_full <= 1'b1;
        w_data <= S_AXI_L_WDATA;
        w_strb <= S_AXI_L_WSTRB;
      end else if (wr_exec_c) begin
        w_full <= 1'b0;
      end
      if (wr_exec_c) begin
        wr_cnt <= wr_cnt + 32'd1;
        bvalid <= 1'b1;
        if (is_rw(aw_idx)) begin
          regs[aw_idx[1:0]] <= merge_strb(regs[aw_idx[1:0]], w_data, w_strb);
          bresp <= RESP_OKAY;
        end else begin
          bresp <= RESP_SLVERR;
        end
      end else if (S_AXI_L_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one capture per AR handshake, held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      rd_cnt <= '0;
    end else if (ar_hs_c) begin
      rvalid <= 1'b1;
      rdata  <= rd_data_c;
      rresp  <= rd_resp_c;
      rd_cnt <= rd_cnt + 32'd1;
    end else if (S_AXI_L_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_slave_lite_regs.sv
// Directed bench for axi_slave_lite_regs: hand-computed expectations checked
// with immediate assertions one clock step at a time.
module tb_axi_slave_lite_regs;

  logic        ACLK;
  logic        ARESET;
  logic [4:0]  S_AXI_L_AWADDR;
  logic        S_AXI_L_AWVALID;
  logic        S_AXI_L_AWREADY;
  logic [31:0] S_AXI_L_WDATA;
  logic [3:0]  S_AXI_L_WSTRB;
  logic        S_AXI_L_WVALID;
  logic        S_AXI_L_WREADY;
  logic [1:0]  S_AXI_L_BRESP;
  logic        S_AXI_L_BVALID;
  logic        S_AXI_L_BREADY;
  logic [4:0]  S_AXI_L_ARADDR;
  logic        S_AXI_L_ARVALID;
  logic        S_AXI_L_ARREADY;
  logic [31:0] S_AXI_L_RDATA;
  logic [1:0]  S_AXI_L_RRESP;
  logic        S_AXI_L_RVALID;
  logic        S_AXI_L_RREADY;
  logic [31:0] CTRL;

  int n_cmp = 0;
  int n_err = 0;

  axi_slave_lite_regs dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .S_AXI_L_AWADDR  (S_AXI_L_AWADDR),
    .S_AXI_L_AWVALID (S_AXI_L_AWVALID),
    .S_AXI_L_AWREADY (S_AXI_L_AWREADY),
    .S_AXI_L_WDATA   (S_AXI_L_WDATA),
    .S_AXI_L_WSTRB   (S_AXI_L_WSTRB),
    .S_AXI_L_WVALID  (S_AXI_L_WVALID),
    .S_AXI_L_WREADY  (S_AXI_L_WREADY),
    .S_AXI_L_BRESP   (S_AXI_L_BRESP),
    .S_AXI_L_BVALID  (S_AXI_L_BVALID),
    .S_AXI_L_BREADY  (S_AXI_L_BREADY),
    .S_AXI_L_ARADDR  (S_AXI_L_ARADDR),
    .S_AXI_L_ARVALID (S_AXI_L_ARVALID),
    .S_AXI_L_ARREADY (S_AXI_L_ARREADY),
    .S_AXI_L_RDATA   (S_AXI_L_RDATA),
    .S_AXI_L_RRESP   (S_AXI_L_RRESP),
    .S_AXI_L_RVALID  (S_AXI_L_RVALID),
    .S_AXI_L_RREADY  (S_AXI_L_RREADY),
    .CTRL            (CTRL)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write with AW and W together: capture edge, then execute edge.
  task automatic do_write(input string tag, input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    S_AXI_L_AWADDR  = addr;
    S_AXI_L_AWVALID = 1'b1;
    S_AXI_L_WDATA   = data;
    S_AXI_L_WSTRB   = strb;
    S_AXI_L_WVALID  = 1'b1;
    tick();
    S_AXI_L_AWVALID = 1'b0;
    S_AXI_L_WVALID  = 1'b0;
    chk({tag, ".bvalid_capture"}, 32'(S_AXI_L_BVALID), 32'd0);
    tick();
    chk({tag, ".bvalid_exec"}, 32'(S_AXI_L_BVALID), 32'd1);
    resp = S_AXI_L_BRESP;
    S_AXI_L_BREADY = 1'b1;
    tick();
    S_AXI_L_BREADY = 1'b0;
    chk({tag, ".bvalid_done"}, 32'(S_AXI_L_BVALID), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [4:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    S_AXI_L_ARADDR  = addr;
    S_AXI_L_ARVALID = 1'b1;
    S_AXI_L_RREADY  = 1'b0;
    tick();
    S_AXI_L_ARVALID = 1'b0;
    chk({tag, ".rvalid"}, 32'(S_AXI_L_RVALID), 32'd1);
    data = S_AXI_L_RDATA;
    resp = S_AXI_L_RRESP;
    S_AXI_L_RREADY = 1'b1;
    tick();
    S_AXI_L_RREADY = 1'b0;
    chk({tag, ".rvalid_done"}, 32'(S_AXI_L_RVALID), 32'd0);
  endtask

  task automatic apply_reset();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    tick();
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;

  initial begin
    ARESET = 1'b1;
    S_AXI_L_AWADDR = '0; S_AXI_L_AWVALID = 1'b0;
    S_AXI_L_WDATA = '0;  S_AXI_L_WSTRB = '0; S_AXI_L_WVALID = 1'b0;
    S_AXI_L_BREADY = 1'b0;
    S_AXI_L_ARADDR = '0; S_AXI_L_ARVALID = 1'b0; S_AXI_L_RREADY = 1'b0;

    // Reset state and ready release
    tick();
    tick();
    chk("rst.awready", 32'(S_AXI_L_AWREADY), 32'd0);
    chk("rst.wready",  32'(S_AXI_L_WREADY),  32'd0);
    chk("rst.arready", 32'(S_AXI_L_ARREADY), 32'd0);
    chk("rst.bvalid",  32'(S_AXI_L_BVALID),  32'd0);
    chk("rst.rvalid",  32'(S_AXI_L_RVALID),  32'd0);
    chk("rst.ctrl",    CTRL,                 32'd0);
    ARESET = 1'b0;
    tick();
    chk("rel.awready", 32'(S_AXI_L_AWREADY), 32'd1);
    chk("rel.wready",  32'(S_AXI_L_WREADY),  32'd1);
    chk("rel.arready", 32'(S_AXI_L_ARREADY), 32'd1);

    // Full-word write then read back
    do_write("wr04", 5'h04, 32'h12345678, 4'hF, resp);
    chk("wr04.bresp", 32'(resp), 32'd0);
    do_read("rd04", 5'h04, rd, resp);
    chk("rd04.data", rd, 32'h12345678);
    chk("rd04.rresp", 32'(resp), 32'd0);

    // W ahead of AW, partial strobe into REG0
    do_write("wr00", 5'h00, 32'h11111111, 4'hF, resp);
    chk("wr00.ctrl", CTRL, 32'h11111111);
    S_AXI_L_WDATA = 32'hAABBCCDD; S_AXI_L_WSTRB = 4'b0011; S_AXI_L_WVALID = 1'b1;
    tick();
    S_AXI_L_WVALID = 1'b0;
    chk("wfirst.wready",  32'(S_AXI_L_WREADY),  32'd0);
    chk("wfirst.awready", 32'(S_AXI_L_AWREADY), 32'd1);
    tick();
    tick();
    chk("wfirst.bvalid_wait", 32'(S_AXI_L_BVALID), 32'd0);
    S_AXI_L_AWADDR = 5'h00; S_AXI_L_AWVALID = 1'b1;
    tick();
    S_AXI_L_AWVALID = 1'b0;
    chk("wfirst.ctrl_before", CTRL, 32'h11111111);
    chk("wfirst.bvalid_cap",  32'(S_AXI_L_BVALID), 32'd0);
    tick();
    chk("wfirst.bvalid", 32'(S_AXI_L_BVALID), 32'd1);
    chk("wfirst.bresp",  32'(S_AXI_L_BRESP),  32'd0);
    chk("wfirst.ctrl",   CTRL, 32'h1111CCDD);
    S_AXI_L_BREADY = 1'b1;
    tick();
    S_AXI_L_BREADY = 1'b0;

    // RO write, unmapped read, zero-strobe write, counters
    apply_reset();
    do_write("wr10", 5'h10, 32'hFFFFFFFF, 4'hF, resp);
    chk("wr10.bresp", 32'(resp), 32'd2);
    do_read("rd1c", 5'h1C, rd, resp);
    chk("rd1c.data",  rd, 32'd0);
    chk("rd1c.rresp", 32'(resp), 32'd2);
    do_read("rdcnt", 5'h14, rd, resp);
    chk("rdcnt.value", rd, 32'd1);
    do_read("wrcnt", 5'h10, rd, resp);
    chk("wrcnt.value", rd, 32'd1);
    chk("wrcnt.rresp", 32'(resp), 32'd0);
    do_write("strb0", 5'h04, 32'hDEADBEEF, 4'h0, resp);
    chk("strb0.bresp", 32'(resp), 32'd0);
    do_read("strb0rd", 5'h04, rd, resp);
    chk("strb0rd.data", rd, 32'd0);

    // Back-pressured response: second write waits for first B handshake
    S_AXI_L_AWADDR = 5'h08; S_AXI_L_AWVALID = 1'b1;
    S_AXI_L_WDATA = 32'hCAFEF00D; S_AXI_L_WSTRB = 4'hF; S_AXI_L_WVALID = 1'b1;
    tick();
    S_AXI_L_AWVALID = 1'b0; S_AXI_L_WVALID = 1'b0;
    tick();
    chk("bp.first_bvalid", 32'(S_AXI_L_BVALID), 32'd1);
    chk("bp.first_bresp",  32'(S_AXI_L_BRESP),  32'd0);
    S_AXI_L_AWADDR = 5'h18; S_AXI_L_AWVALID = 1'b1;
    S_AXI_L_WDATA = 32'h0000DEAD; S_AXI_L_WVALID = 1'b1;
    tick();
    S_AXI_L_AWVALID = 1'b0; S_AXI_L_WVALID = 1'b0;
    chk("bp.awready_stall", 32'(S_AXI_L_AWREADY), 32'd0);
    chk("bp.wready_stall",  32'(S_AXI_L_WREADY),  32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.hold_bvalid", 32'(S_AXI_L_BVALID), 32'd1);
      chk("bp.hold_bresp",  32'(S_AXI_L_BRESP),  32'd0);
    end
    S_AXI_L_BREADY = 1'b1;
    tick();
    chk("bp.second_bvalid", 32'(S_AXI_L_BVALID), 32'd1);
    chk("bp.second_bresp",  32'(S_AXI_L_BRESP),  32'd2);
    chk("bp.awready_free",  32'(S_AXI_L_AWREADY), 32'd1);
    tick();
    S_AXI_L_BREADY = 1'b0;
    chk("bp.bvalid_done", 32'(S_AXI_L_BVALID), 32'd0);
    do_read("bp.rd08", 5'h08, rd, resp);
    chk("bp.rd08.data", rd, 32'hCAFEF00D);
    do_read("bp.wrcnt", 5'h10, rd, resp);
    chk("bp.wrcnt.value", rd, 32'd4);

    // Asynchronous reset while a response is pending
    S_AXI_L_AWADDR = 5'h0C; S_AXI_L_AWVALID = 1'b1;
    S_AXI_L_WDATA = 32'h00000055; S_AXI_L_WVALID = 1'b1;
    tick();
    S_AXI_L_AWVALID = 1'b0; S_AXI_L_WVALID = 1'b0;
    tick();
    chk("ar.pending_bvalid", 32'(S_AXI_L_BVALID), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("ar.bvalid",  32'(S_AXI_L_BVALID),  32'd0);
    chk("ar.awready", 32'(S_AXI_L_AWREADY), 32'd0);
    chk("ar.arready", 32'(S_AXI_L_ARREADY), 32'd0);
    tick();
    ARESET = 1'b0;
    tick();
    chk("ar.bvalid_after", 32'(S_AXI_L_BVALID), 32'd0);
    do_write("ar.wr00", 5'h00, 32'h00000077, 4'hF, resp);
    chk("ar.wr00.bresp", 32'(resp), 32'd0);
    chk("ar.ctrl", CTRL, 32'h00000077);
    do_read("ar.wrcnt", 5'h10, rd, resp);
    chk("ar.wrcnt.value", rd, 32'd1);
    do_read("ar.rd0c", 5'h0C, rd, resp);
    chk("ar.rd0c.data", rd, 32'd0);

    // Same-edge write execution and read of REG3 returns the old value
    S_AXI_L_AWADDR = 5'h0C; S_AXI_L_AWVALID = 1'b1;
    S_AXI_L_WDATA = 32'h00000099; S_AXI_L_WSTRB = 4'hF; S_AXI_L_WVALID = 1'b1;
    tick();
    S_AXI_L_AWVALID = 1'b0; S_AXI_L_WVALID = 1'b0;
    S_AXI_L_ARADDR = 5'h0C; S_AXI_L_ARVALID = 1'b1; S_AXI_L_RREADY = 1'b0;
    tick();
    S_AXI_L_ARVALID = 1'b0;
    chk("coll.rvalid", 32'(S_AXI_L_RVALID), 32'd1);
    chk("coll.rdata",  S_AXI_L_RDATA, 32'd0);
    chk("coll.bvalid", 32'(S_AXI_L_BVALID), 32'd1);
    S_AXI_L_BREADY = 1'b1; S_AXI_L_RREADY = 1'b1;
    tick();
    S_AXI_L_BREADY = 1'b0; S_AXI_L_RREADY = 1'b0;
    do_read("coll.rd0c", 5'h0C, rd, resp);
    chk("coll.rd0c.data", rd, 32'h00000099);

    // Back-to-back reads of RD_CNT, one per cycle
    S_AXI_L_ARADDR = 5'h14; S_AXI_L_ARVALID = 1'b1; S_AXI_L_RREADY = 1'b1;
    #1;
    chk("b2b.arready0", 32'(S_AXI_L_ARREADY), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b.rvalid",  32'(S_AXI_L_RVALID),  32'd1);
      chk("b2b.arready", 32'(S_AXI_L_ARREADY), 32'd1);
      chk("b2b.rdata",   S_AXI_L_RDATA, 32'(4 + i));
    end
    S_AXI_L_ARVALID = 1'b0;
    tick();
    S_AXI_L_RREADY = 1'b0;
    chk("b2b.rvalid_done", 32'(S_AXI_L_RVALID), 32'd0);
    do_read("b2b.final", 5'h14, rd, resp);
    chk("b2b.final.data", rd, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
